// File: rtl/karatsuba_pkg.sv
// Shared types and helpers for the Karatsuba sequential multiplier.
package karatsuba_pkg;

   typedef enum logic [2:0] {
      IDLE,
      Z0,
      Z2,
      Z1,
      COMB,
      SGN
   } kara_state_t;

   function automatic int kara_latency(input int width);
      return 3 * (width / 2 + 1) + 2;
   endfunction

endpackage

// File: rtl/karatsuba_shift_mul.sv
// N x N unsigned shift-add multiplier; loads in one edge, then needs exactly N run cycles.
module karatsuba_shift_mul #(
   parameter int N = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           run,
   input  logic [N-1:0]   x,
   input  logic [N-1:0]   y,
   output logic [2*N-1:0] result,
   output logic           done
);
   localparam int CW = $clog2(N + 1);

   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] partial;

   // result is the accumulator plus this cycle's partial product, so it is the
   // full product during the final run cycle when done is high.
   assign partial = mplier[0] ? mcand : '0;
   assign result  = acc + partial;
   assign done    = run && (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{N{1'b0}}, x};
         mplier <= y;
         cnt    <= CW'(N);
      end else if (run && (cnt != '0)) begin
         acc    <= result;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/karatsuba_seq_mul.sv
// One-level Karatsuba multiplier: three half-width sub-products on a shared
// shift-add unit, then combine and sign fix-up.
//
// state | meaning
// IDLE  | waiting for start
// Z0    | al*bl on the sub-multiplier
// Z2    | ah*bh on the sub-multiplier
// Z1    | (al+ah)*(bl+bh) on the sub-multiplier
// COMB  | z2<<W + (z1-z2-z0)<<H + z0 into comb_q
// SGN   | apply sign, done pulse; start here chains the next operation
module karatsuba_seq_mul
   import karatsuba_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);
   localparam int H = WIDTH / 2;
   localparam int N = H + 1;

   kara_state_t state, state_nxt;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   op_a, op_b;
   logic               sign_q;
   logic [2*N-1:0]     z0, z1, z2;
   logic [2*WIDTH-1:0] comb_nxt, comb_q, result, product_q;
   logic               accept;
   logic               mul_load, mul_run, mul_done;
   logic [N-1:0]       mul_x, mul_y;
   logic [2*N-1:0]     mul_result;

   assign mag_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign mag_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      mul_load  = 1'b0;
      mul_x     = '0;
      mul_y     = '0;
      unique case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = Z0;
         end
         Z0: if (mul_done) begin
            state_nxt = Z2;
            mul_load  = 1'b1;
            mul_x     = {1'b0, op_a[WIDTH-1:H]};
            mul_y     = {1'b0, op_b[WIDTH-1:H]};
         end
         Z2: if (mul_done) begin
            state_nxt = Z1;
            mul_load  = 1'b1;
            mul_x     = {1'b0, op_a[H-1:0]} + {1'b0, op_a[WIDTH-1:H]};
            mul_y     = {1'b0, op_b[H-1:0]} + {1'b0, op_b[WIDTH-1:H]};
         end
         Z1: if (mul_done) state_nxt = COMB;
         COMB: state_nxt = SGN;
         SGN: begin
            state_nxt = IDLE;
            if (start) begin
               accept    = 1'b1;
               state_nxt = Z0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) begin
         mul_load = 1'b1;
         mul_x    = {1'b0, mag_a[H-1:0]};
         mul_y    = {1'b0, mag_b[H-1:0]};
      end
   end

   assign mul_run = (state == Z0) || (state == Z2) || (state == Z1);

   karatsuba_shift_mul #(.N(N)) u_shift_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (mul_load),
      .run    (mul_run),
      .x      (mul_x),
      .y      (mul_y),
      .result (mul_result),
      .done   (mul_done)
   );

   // Evaluated modulo 2^(2*WIDTH): the true product fits, so the wrap in the
   // middle term cancels exactly and the wider intermediate is not needed.
   assign comb_nxt = ((2*WIDTH)'(z2) << WIDTH)
                   + (((2*WIDTH)'(z1) - (2*WIDTH)'(z2) - (2*WIDTH)'(z0)) << H)
                   + (2*WIDTH)'(z0);

   assign result  = sign_q ? (~comb_q + (2*WIDTH)'(1)) : comb_q;
   assign product = (state == SGN) ? result : product_q;
   assign busy    = (state != IDLE);
   assign done    = (state == SGN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         sign_q    <= 1'b0;
         z0        <= '0;
         z1        <= '0;
         z2        <= '0;
         comb_q    <= '0;
         product_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a   <= mag_a;
            op_b   <= mag_b;
            sign_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
         end
         if (state == Z0 && mul_done) z0 <= mul_result;
         if (state == Z2 && mul_done) z2 <= mul_result;
         if (state == Z1 && mul_done) z1 <= mul_result;
         if (state == COMB) comb_q <= comb_nxt;
         if (state == SGN) product_q <= result;
      end
   end

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Directed bench for karatsuba_seq_mul at WIDTH=16 and WIDTH=8.
module tb_karatsuba_seq_mul;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;

   logic        start = 1'b0, sm = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [31:0] product;
   logic        busy, done;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] product8;
   logic        busy8, done8;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int done_cnt8 = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done)  done_cnt++;
      if (done8) done_cnt8++;
   end

   karatsuba_seq_mul #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
      .a(a), .b(b), .product(product), .busy(busy), .done(done)
   );

   karatsuba_seq_mul #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .product(product8), .busy(busy8), .done(done8)
   );

   // Drives one operation and records what it observed; checking is left to the caller.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ism,
                        output logic [31:0] prod, output int lat, output int busy_cyc,
                        output logic done_after, output logic busy_after,
                        output logic [31:0] prod_after);
      @(negedge clk);
      a = ia; b = ib; sm = ism; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      busy_cyc = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busy_cyc++;
      end while (!done && lat < 100);
      prod = product;
      @(negedge clk);
      done_after = done;
      busy_after = busy;
      prod_after = product;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #3;
      checks++;
      if (product !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset16: product=%h busy=%b done=%b, required 0/0/0", product, busy, done);
      end
      checks++;
      if (product8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL reset8: product=%h busy=%b done=%b, required 0/0/0", product8, busy8, done8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [15:0] va  [10] = '{16'd3, 16'hFFFF, 16'd0, 16'd1023, 16'hFFFD,
                             16'h8000, 16'h8000, 16'hFFFF, 16'h8000, 16'h1234};
   logic [15:0] vb  [10] = '{16'd4, 16'hFFFF, 16'd123, 16'd1023, 16'd4,
                             16'h8000, 16'd1, 16'hFFFF, 16'h8000, 16'hFFFE};
   logic        vs  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] vexp[10] = '{32'd12, 32'hFFFE0001, 32'd0, 32'd1046529, 32'hFFFFFFF4,
                             32'h40000000, 32'hFFFF8000, 32'h00000001, 32'h40000000, 32'hFFFFDB98};

   task automatic test_arith();
      logic [31:0] p, pa;
      int          lat, bc;
      logic        da, ba;
      for (int i = 0; i < 10; i++) begin
         do_op(va[i], vb[i], vs[i], p, lat, bc, da, ba, pa);
         checks++;
         if (p !== vexp[i]) begin
            errors++;
            $display("FAIL arith[%0d] product: got %h, required %h", i, p, vexp[i]);
         end
         checks++;
         if (lat !== 29) begin
            errors++;
            $display("FAIL arith[%0d] latency: got %0d, required 29", i, lat);
         end
         checks++;
         if (bc !== 29) begin
            errors++;
            $display("FAIL arith[%0d] busy cycles: got %0d, required 29", i, bc);
         end
         checks++;
         if (da !== 1'b0 || ba !== 1'b0) begin
            errors++;
            $display("FAIL arith[%0d] after done: done=%b busy=%b, required 0/0", i, da, ba);
         end
         checks++;
         if (pa !== vexp[i]) begin
            errors++;
            $display("FAIL arith[%0d] product hold: got %h, required %h", i, pa, vexp[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int snap, lat;
      snap = done_cnt;
      @(negedge clk);
      a = 16'd123; b = 16'd456; sm = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 8) begin
            a = 16'd7; b = 16'hFFF0; sm = 1'b1; start = 1'b1;
         end else if (lat == 9) begin
            start = 1'b0;
         end
      end while (!done && lat < 100);
      checks++;
      if (product !== 32'd56088) begin
         errors++;
         $display("FAIL busy_ignore product: got %0d, required 56088", product);
      end
      checks++;
      if (lat !== 29) begin
         errors++;
         $display("FAIL busy_ignore latency: got %0d, required 29", lat);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (done_cnt - snap !== 1) begin
         errors++;
         $display("FAIL busy_ignore done pulses: got %0d, required 1", done_cnt - snap);
      end
   endtask

   task automatic test_reset_abort();
      int          snap, lat, bc;
      logic [31:0] p, pa;
      logic        da, ba;
      @(negedge clk);
      a = 16'd999; b = 16'd999; sm = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      snap = done_cnt;
      rst_n = 1'b0;
      #1;
      checks++;
      if (product !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort outputs: product=%h busy=%b done=%b, required 0/0/0", product, busy, done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (35) @(negedge clk);
      checks++;
      if (done_cnt !== snap || product !== 32'h0) begin
         errors++;
         $display("FAIL abort no done: pulses=%0d product=%h, required 0 pulses product 0", done_cnt - snap, product);
      end
      do_op(16'd10, 16'd20, 1'b0, p, lat, bc, da, ba, pa);
      checks++;
      if (p !== 32'd200 || lat !== 29) begin
         errors++;
         $display("FAIL abort recover: product=%0d latency=%0d, required 200/29", p, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic busy_gap;
      @(negedge clk);
      a = 16'd100; b = 16'd200; sm = 1'b0; start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 100);
      checks++;
      if (lat !== 29 || product !== 32'd20000) begin
         errors++;
         $display("FAIL b2b first: latency=%0d product=%0d, required 29/20000", lat, product);
      end
      a = 16'hFED4; b = 16'd5; sm = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      busy_gap = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!busy) busy_gap = 1'b1;
         if (lat == 5) begin
            checks++;
            if (product !== 32'd20000) begin
               errors++;
               $display("FAIL b2b hold: got %0d, required 20000", product);
            end
         end
      end while (!done && lat < 100);
      checks++;
      if (lat !== 29 || busy_gap !== 1'b0) begin
         errors++;
         $display("FAIL b2b second latency: got %0d gap=%b, required 29 gap=0", lat, busy_gap);
      end
      checks++;
      if (product !== 32'hFFFFFA24) begin
         errors++;
         $display("FAIL b2b second product: got %h, required fffffa24", product);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b end: done=%b busy=%b, required 0/0", done, busy);
      end
   endtask

   task automatic test_back_to_back_w8();
      int lat;
      @(negedge clk);
      a8 = 8'd12; b8 = 8'd13; sm8 = 1'b0; start8 = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done8 && lat < 100);
      checks++;
      if (lat !== 17 || product8 !== 16'd156) begin
         errors++;
         $display("FAIL w8 first: latency=%0d product=%0d, required 17/156", lat, product8);
      end
      a8 = 8'd255; b8 = 8'd255;
      @(posedge clk);
      #1 start8 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done8 && lat < 100);
      checks++;
      if (lat !== 17 || product8 !== 16'd65025) begin
         errors++;
         $display("FAIL w8 second: latency=%0d product=%0d, required 17/65025", lat, product8);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || product8 !== 16'd65025) begin
         errors++;
         $display("FAIL w8 end: done=%b busy=%b product=%0d, required 0/0/65025", done8, busy8, product8);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_start_while_busy();
      test_reset_abort();
      test_back_to_back();
      test_back_to_back_w8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
